// File: rtl/float_arb_pkg.sv
// float_arb_pkg: shared state type, width helper and round-robin pick for float_unit_arbiter
package float_arb_pkg;

    typedef enum logic {ARB, LOCKED} arb_state_t;

    localparam int STAT_W = 32;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First set bit of valid at or after ptr, wrapping over n entries; -1 when none is set.
    // Scanning from the far end lets the nearest candidate overwrite the result last.
    function automatic int rr_pick(input logic [7:0] valid, input int n, input int ptr);
        rr_pick = -1;
        for (int k = n - 1; k >= 0; k--)
            if (valid[3'((ptr + k) % n)]) rr_pick = (ptr + k) % n;
    endfunction

endpackage

// File: rtl/float_tag_fifo.sv
// float_tag_fifo: requester-ID FIFO tracking operations outstanding in the float unit
//   aclk/aresetn : clock, async active-low reset (pointers and count only)
//   push/push_id : enqueue the ID of an issued operation
//   pop          : dequeue the head when its result is delivered
//   head/count   : oldest outstanding ID and number of entries
module float_tag_fifo
    import float_arb_pkg::*;
#(
    parameter int W     = 2,
    parameter int DEPTH = 32,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          push,
    input  logic [W-1:0]  push_id,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);

    localparam int PW = id_w(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    // explicit wrap so non-power-of-two depths work
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head = mem[rd_ptr];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= nxt(wr_ptr);
            if (pop) rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge aclk)
        if (push) mem[wr_ptr] <= push_id;

endmodule

// File: rtl/float_unit_arbiter.sv
// float_unit_arbiter: shares one pipelined in-order float unit among NUM_REQ requesters
//   req_a/b_tdata, req_tvalid, req_tready : per-requester issue streams (packed, requester i at [i*SIZE +: SIZE])
//   rsp_tdata, rsp_tvalid, rsp_tready     : shared result data, valid one-hot on the owning requester
//   fu_a/b_*, fu_result_*                 : the single float unit's operand and result streams
//   err_orphan                            : sticky, a result arrived with no operation outstanding
//   FLOAT_ARB_STATS_EN adds issue_count (per-requester accepted issues) and stall_count (cycles unit not ready)
module float_unit_arbiter
    import float_arb_pkg::*;
#(
    parameter int SIZE            = 32,
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 32
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [NUM_REQ*SIZE-1:0] req_a_tdata,
    input  logic [NUM_REQ*SIZE-1:0] req_b_tdata,
    input  logic [NUM_REQ-1:0]      req_tvalid,
    output logic [NUM_REQ-1:0]      req_tready,
    output logic [SIZE-1:0]         rsp_tdata,
    output logic [NUM_REQ-1:0]      rsp_tvalid,
    input  logic [NUM_REQ-1:0]      rsp_tready,
    output logic [SIZE-1:0]         fu_a_tdata,
    output logic [SIZE-1:0]         fu_b_tdata,
    output logic                    fu_a_tvalid,
    output logic                    fu_b_tvalid,
    input  logic                    fu_a_tready,
    input  logic                    fu_b_tready,
    input  logic [SIZE-1:0]         fu_result_tdata,
    input  logic                    fu_result_tvalid,
    output logic                    fu_result_tready,
    output logic                    err_orphan
`ifdef FLOAT_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0] issue_count,
    output logic [STAT_W-1:0]         stall_count
`endif
);

    localparam int ID_W = id_w(NUM_REQ);
    localparam int CW   = $clog2(MAX_OUTSTANDING + 1);

    arb_state_t      state;
    logic [ID_W-1:0] rr_ptr, lock_id, grant, head;
    logic [CW-1:0]   count;
    logic            fu_valid, hs, has_tag, pop;
    int              pick;

    always_comb begin
        pick     = rr_pick(8'(req_tvalid), NUM_REQ, int'(rr_ptr));
        grant    = (state == LOCKED) ? lock_id : (pick < 0) ? '0 : ID_W'(pick);
        // a locked grant was admitted below the limit and nothing has been pushed since
        fu_valid = aresetn && (state == LOCKED || (count != CW'(MAX_OUTSTANDING) && |req_tvalid));
        hs       = fu_valid && fu_a_tready && fu_b_tready;
        has_tag  = count != '0;
        pop      = has_tag && fu_result_tvalid && rsp_tready[head];
    end

    assign fu_a_tvalid      = fu_valid;
    assign fu_b_tvalid      = fu_valid;
    assign fu_a_tdata       = req_a_tdata[grant*SIZE +: SIZE];
    assign fu_b_tdata       = req_b_tdata[grant*SIZE +: SIZE];
    assign req_tready       = hs ? NUM_REQ'(1) << grant : '0;
    assign rsp_tdata        = fu_result_tdata;
    assign rsp_tvalid       = (has_tag && fu_result_tvalid) ? NUM_REQ'(1) << head : '0;
    // with nothing outstanding a stray result is drained so the unit cannot wedge
    assign fu_result_tready = has_tag ? rsp_tready[head] : (aresetn && fu_result_tvalid);

    float_tag_fifo #(.W(ID_W), .DEPTH(MAX_OUTSTANDING)) u_tags (
        .aclk    (aclk),
        .aresetn (aresetn),
        .push    (hs),
        .push_id (grant),
        .pop     (pop),
        .head    (head),
        .count   (count)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= ARB;
            rr_ptr     <= '0;
            lock_id    <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (hs) begin
                state  <= ARB;
                rr_ptr <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
            end else if (fu_valid) begin
                state   <= LOCKED;
                lock_id <= grant;
            end
            if (!has_tag && fu_result_tvalid) err_orphan <= 1'b1;
        end
    end

`ifdef FLOAT_ARB_STATS_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            issue_count <= '0;
            stall_count <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                if (req_tready[i]) issue_count[i*STAT_W +: STAT_W] <= issue_count[i*STAT_W +: STAT_W] + 1'b1;
            if (fu_valid && !fu_a_tready) stall_count <= stall_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_float_unit_arbiter.sv
// tb_float_unit_arbiter: directed scoreboard bench with a small latency-LAT float unit model
module tb_float_unit_arbiter;

    localparam int NR = 4, MAX = 4, LAT = 4;

    typedef struct packed {logic [1:0] id; logic [31:0] d;} rsp_t;
    typedef struct packed {logic [31:0] d; int due;} u_t;

    logic            aclk = 0, aresetn = 0;
    logic [NR*32-1:0] req_a_tdata = '0, req_b_tdata = '0;
    logic [NR-1:0]   req_tvalid = '0, rsp_tready = '1;
    logic [NR-1:0]   req_tready, rsp_tvalid;
    logic [31:0]     rsp_tdata, fu_a_tdata, fu_b_tdata;
    logic [31:0]     fu_result_tdata = '0, inj_data = '0;
    logic            fu_a_tvalid, fu_b_tvalid, fu_result_tready, err_orphan;
    logic            unit_rdy = 1, fu_result_tvalid = 0, inject = 0;
`ifdef FLOAT_ARB_STATS_EN
    logic [NR*32-1:0] issue_count;
    logic [31:0]      stall_count;
`endif

    int   total = 0, bad = 0, n_acc = 0, n_rsp = 0, cyc = 0;
    int   wr [NR] = '{default: 0};
    int   rd [NR] = '{default: 0};
    logic [31:0] ra [NR][64];
    logic [31:0] rb [NR][64];
    int   exp_iss [$];
    rsp_t exp_rsp [$];
    u_t   uq [$];

    always #5 aclk = ~aclk;

    float_unit_arbiter #(.SIZE(32), .NUM_REQ(NR), .MAX_OUTSTANDING(MAX)) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .req_a_tdata      (req_a_tdata),
        .req_b_tdata      (req_b_tdata),
        .req_tvalid       (req_tvalid),
        .req_tready       (req_tready),
        .rsp_tdata        (rsp_tdata),
        .rsp_tvalid       (rsp_tvalid),
        .rsp_tready       (rsp_tready),
        .fu_a_tdata       (fu_a_tdata),
        .fu_b_tdata       (fu_b_tdata),
        .fu_a_tvalid      (fu_a_tvalid),
        .fu_b_tvalid      (fu_b_tvalid),
        .fu_a_tready      (unit_rdy),
        .fu_b_tready      (unit_rdy),
        .fu_result_tdata  (fu_result_tdata),
        .fu_result_tvalid (fu_result_tvalid),
        .fu_result_tready (fu_result_tready),
        .err_orphan       (err_orphan)
`ifdef FLOAT_ARB_STATS_EN
        ,
        .issue_count      (issue_count),
        .stall_count      (stall_count)
`endif
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got 0x%h want 0x%h", name, got, want);
        end
    endtask

    task automatic req(input int i, input logic [31:0] a, input logic [31:0] b);
        ra[i][wr[i] % 64] = a;
        rb[i][wr[i] % 64] = b;
        wr[i]++;
    endtask

    task automatic expect_rsp(input int i, input logic [31:0] r);
        rsp_t e;
        e.id = 2'(i);
        e.d  = r;
        exp_iss.push_back(i);
        exp_rsp.push_back(e);
    endtask

    // one clock: note acceptances, then present each requester's next operand after the edge
    task automatic tick();
        logic [NR-1:0] acc;
        @(negedge aclk);
        acc = req_tvalid & req_tready;
        @(posedge aclk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (acc[i]) rd[i]++;
            req_tvalid[i] = rd[i] != wr[i];
            req_a_tdata[i*32 +: 32] = ra[i][rd[i] % 64];
            req_b_tdata[i*32 +: 32] = rb[i][rd[i] % 64];
        end
        #1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_rsp.size() != 0 || exp_iss.size() != 0) && n < 400) begin
            tick();
            n++;
        end
        chk({name, "_drain_left"}, 32'(exp_rsp.size() + exp_iss.size()), 0);
    endtask

    function automatic logic [31:0] unit_fn(input logic [31:0] a, input logic [31:0] b);
        case (a)
            32'h41100000: return 32'h40400000;
            32'h41800000: return 32'h40800000;
            32'h40800000: return 32'h40000000;
            32'h42C80000: return 32'h41200000;
            32'h3F800000: return 32'h3F800000;
            default:      return a ^ b;
        endcase
    endfunction

    // in-order float unit: result visible LAT cycles after issue, held until accepted
    initial forever begin
        logic        fin, fout;
        logic [31:0] fd;
        @(negedge aclk);
        fin  = fu_a_tvalid && fu_b_tvalid && unit_rdy;
        fd   = unit_fn(fu_a_tdata, fu_b_tdata);
        fout = fu_result_tvalid && fu_result_tready;
        @(posedge aclk);
        #1;
        cyc++;
        if (!aresetn) uq.delete();
        else begin
            if (fout && uq.size() != 0) void'(uq.pop_front());
            if (fin) uq.push_back('{fd, cyc + LAT});
        end
        fu_result_tvalid = inject;
        fu_result_tdata  = inj_data;
        if (!inject && uq.size() != 0) begin
            fu_result_tvalid = uq[0].due <= cyc;
            fu_result_tdata  = uq[0].d;
        end
    end

    // monitor: grants and deliveries against the scoreboard queues
    always @(negedge aclk) begin
        int   g;
        rsp_t e;
        if (|req_tready) begin
            g = 0;
            for (int i = 0; i < NR; i++) if (req_tready[i]) g = i;
            chk("tready_onehot", 32'(req_tready), 32'(1) << g);
            chk("fu_a_data", fu_a_tdata, ra[g][rd[g] % 64]);
            chk("fu_b_data", fu_b_tdata, rb[g][rd[g] % 64]);
            chk("outstanding_at_issue", 32'(n_acc - n_rsp), 32'((n_acc - n_rsp) < MAX ? n_acc - n_rsp : MAX - 1));
            if (exp_iss.size() == 0) begin
                total++;
                bad++;
                $display("FAIL issue_unexpected: got grant %0d want none", g);
            end else chk("grant_order", 32'(g), 32'(exp_iss.pop_front()));
            n_acc++;
        end
        if (|(rsp_tvalid & rsp_tready)) begin
            if (exp_rsp.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected: got valid %b want none", rsp_tvalid);
            end else begin
                e = exp_rsp.pop_front();
                chk("rsp_valid", 32'(rsp_tvalid), 32'(1) << e.id);
                chk("rsp_data", rsp_tdata, e.d);
            end
            n_rsp++;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int base;
        // outputs stay quiet under reset even with a request pending and the unit ready
        req(0, 32'h00001234, 32'h00005a5a);
        repeat (3) tick();
        chk("rst_req_tready", 32'(req_tready), 0);
        chk("rst_fu_a_tvalid", 32'(fu_a_tvalid), 0);
        chk("rst_fu_b_tvalid", 32'(fu_b_tvalid), 0);
        chk("rst_rsp_tvalid", 32'(rsp_tvalid), 0);
        chk("rst_res_tready", 32'(fu_result_tready), 0);
        chk("rst_orphan", 32'(err_orphan), 0);
        expect_rsp(0, 32'h0000486e);
        aresetn = 1;
        drain("first");
        // single sqrt(9.0) from requester 2
        req(2, 32'h41100000, 0);
        expect_rsp(2, 32'h40400000);
        drain("single");
        chk("single_orphan", 32'(err_orphan), 0);
        // lock on requester 1 (rr_ptr=3) while 0 and 2 arrive; then 2 before 0
        unit_rdy = 0;
        req(1, 32'h40800000, 0);
        repeat (2) tick();
        req(0, 32'h42C80000, 0);
        req(2, 32'h3F800000, 0);
        expect_rsp(1, 32'h40000000);
        expect_rsp(2, 32'h3F800000);
        expect_rsp(0, 32'h41200000);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("lock_valid", 32'(fu_a_tvalid), 1);
            chk("lock_data", fu_a_tdata, 32'h40800000);
        end
        unit_rdy = 1;
        drain("locked");
        // tag FIFO full: results held, exactly MAX issues go out
        rsp_tready = '0;
        for (int k = 0; k < 5; k++) begin
            req(1, 32'h100 + k, 32'h5a5a);
            expect_rsp(1, (32'h100 + k) ^ 32'h5a5a);
        end
        base = n_acc;
        repeat (15) tick();
        chk("full_accepts", 32'(n_acc - base), 4);
        chk("full_still_waiting", 32'(req_tvalid[1]), 1);
        chk("full_res_tready", 32'(fu_result_tready), 0);
        rsp_tready = '1;
        drain("full");
        chk("full_total", 32'(n_acc - base), 5);
        // requester 3 holds its result at the head; others wait behind it
        rsp_tready[3] = 0;
        req(3, 32'h41800000, 0);
        expect_rsp(3, 32'h40800000);
        repeat (2) tick();
        req(0, 32'h40800000, 0);
        expect_rsp(0, 32'h40000000);
        req(1, 32'h3F800000, 0);
        expect_rsp(1, 32'h3F800000);
        base = n_rsp;
        repeat (15) tick();
        chk("hold_rsp_tvalid", 32'(rsp_tvalid), 32'b1000);
        chk("hold_rsp_tdata", rsp_tdata, 32'h40800000);
        chk("hold_res_tready", 32'(fu_result_tready), 0);
        chk("hold_no_delivery", 32'(n_rsp - base), 0);
        rsp_tready = '1;
        drain("hold");
        // orphan result with nothing outstanding, then reset clears the flag
        inject = 1;
        inj_data = 32'hDEADBEEF;
        tick();
        chk("orphan_drain_ready", 32'(fu_result_tready), 1);
        chk("orphan_no_rsp", 32'(rsp_tvalid), 0);
        inject = 0;
        tick();
        chk("orphan_set", 32'(err_orphan), 1);
        repeat (3) tick();
        chk("orphan_sticky", 32'(err_orphan), 1);
        aresetn = 0;
        #1;
        chk("orphan_reset", 32'(err_orphan), 0);
        repeat (2) tick();
        aresetn = 1;
        tick();
        chk("post_rst_rsp_tvalid", 32'(rsp_tvalid), 0);
        chk("post_rst_res_tready", 32'(fu_result_tready), 0);
        // all four continuously valid from rr_ptr=0: strict 0,1,2,3 rotation
        for (int k = 0; k < 25; k++)
            for (int i = 0; i < NR; i++) begin
                req(i, 32'h10000000 * i + k, 32'h5a5a);
                expect_rsp(i, (32'h10000000 * i + k) ^ 32'h5a5a);
            end
        drain("rr");
        chk("rr_orphan", 32'(err_orphan), 0);
`ifdef FLOAT_ARB_STATS_EN
        for (int i = 0; i < NR; i++) chk("issue_count", issue_count[i*32 +: 32], 25);
        chk("stall_count", stall_count, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
